// File: rtl/gamma_pixel_packer.sv
// Packs the R,G,B gamma-corrected sample stream into 24-bit pixels and queues
// them in a first-word-fall-through FIFO with sticky overflow / sync-error flags.
module gamma_pixel_packer #(
  parameter int DEPTH   = 4,
  parameter int LEVEL_W = 3
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iVALID,
  input  logic               iSOF,
  input  logic [7:0]         iDATA,
  output logic [23:0]        oPIXEL,
  output logic               oVALID,
  input  logic               iREADY,
  output logic               oSOF,
  output logic [LEVEL_W-1:0] oLEVEL,
  output logic               oOVERFLOW,
  output logic               oSYNC_ERR,
  input  logic               iCLR_ERR
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } ch_t;

  ch_t               r_ch;
  ch_t               w_ch_nxt;
  logic              r_v_d;
  logic              r_sof_d;
  logic [7:0]        r_red;
  logic [7:0]        r_grn;
  logic              r_pix_sof;
  logic [24:0]       r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LEVEL_W-1:0] r_level;
  logic              r_ovf;
  logic              r_serr;

  logic              w_cap_r;
  logic              w_cap_g;
  logic              w_push;
  logic              w_sync_set;
  logic              w_pop;
  logic              w_full;
  logic              w_acc;
  logic              w_drop;
  logic [24:0]       w_pixel;
  logic [24:0]       w_head;

  // Valid/SOF delayed one clock so they line up with the registered LUT data
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_v_d   <= 1'b0;
      r_sof_d <= 1'b0;
    end else begin
      r_v_d   <= iVALID;
      r_sof_d <= iSOF;
    end
  end

  // Channel state register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_ch <= CH_R;
    end else begin
      r_ch <= w_ch_nxt;
    end
  end

  // Channel sequencing; an SOF sample always restarts the pixel as R
  always_comb begin
    w_ch_nxt   = r_ch;
    w_cap_r    = 1'b0;
    w_cap_g    = 1'b0;
    w_push     = 1'b0;
    w_sync_set = 1'b0;
    if (r_v_d) begin
      if (r_sof_d) begin
        w_cap_r    = 1'b1;
        w_ch_nxt   = CH_G;
        w_sync_set = (r_ch != CH_R);
      end else begin
        case (r_ch)
          CH_R: begin
            w_cap_r  = 1'b1;
            w_ch_nxt = CH_G;
          end
          CH_G: begin
            w_cap_g  = 1'b1;
            w_ch_nxt = CH_B;
          end
          CH_B: begin
            w_push   = 1'b1;
            w_ch_nxt = CH_R;
          end
          default: begin
            w_ch_nxt = CH_R;
          end
        endcase
      end
    end else begin
      w_ch_nxt = r_ch;
    end
  end

  // Partial pixel holding registers
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_red     <= 8'd0;
      r_grn     <= 8'd0;
      r_pix_sof <= 1'b0;
    end else begin
      if (w_cap_r) begin
        r_red     <= iDATA;
        r_pix_sof <= r_sof_d;
      end
      if (w_cap_g) begin
        r_grn <= iDATA;
      end
    end
  end

  assign w_pixel = {r_pix_sof, r_red, r_grn, iDATA};
  assign w_pop   = oVALID && iREADY;
  assign w_full  = (r_level == LEVEL_W'(DEPTH));
  // A full FIFO still takes a pixel when its head leaves on the same edge
  assign w_acc   = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && !w_acc;

  // FIFO storage and pointers
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 25'd0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_acc) begin
        r_mem[r_wr_ptr] <= w_pixel;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  // Occupancy counter
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_level <= '0;
    end else begin
      case ({w_acc, w_pop})
        2'b10:   r_level <= r_level + LEVEL_W'(1);
        2'b01:   r_level <= r_level - LEVEL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky error flags; a new error beats a clear in the same cycle
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_ovf  <= 1'b0;
      r_serr <= 1'b0;
    end else begin
      r_ovf  <= w_drop     | (r_ovf  & ~iCLR_ERR);
      r_serr <= w_sync_set | (r_serr & ~iCLR_ERR);
    end
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign oVALID    = (r_level != '0);
  assign oPIXEL    = w_head[23:0];
  assign oSOF      = oVALID & w_head[24];
  assign oLEVEL    = r_level;
  assign oOVERFLOW = r_ovf;
  assign oSYNC_ERR = r_serr;

endmodule

// File: tb/tb_gamma_pixel_packer.sv
// Self-checking bench for gamma_pixel_packer: directed scenarios plus a random
// run, all checked against a queue-based sample/pixel reference model.
module tb_gamma_pixel_packer;

  localparam int DEPTH   = 4;
  localparam int LEVEL_W = 3;

  logic               iCLK = 1'b0;
  logic               iRST_N;
  logic               iVALID;
  logic               iSOF;
  logic [7:0]         iDATA;
  logic [23:0]        oPIXEL;
  logic               oVALID;
  logic               iREADY;
  logic               oSOF;
  logic [LEVEL_W-1:0] oLEVEL;
  logic               oOVERFLOW;
  logic               oSYNC_ERR;
  logic               iCLR_ERR;

  gamma_pixel_packer #(.DEPTH(DEPTH), .LEVEL_W(LEVEL_W)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iVALID(iVALID), .iSOF(iSOF), .iDATA(iDATA),
    .oPIXEL(oPIXEL), .oVALID(oVALID), .iREADY(iREADY), .oSOF(oSOF),
    .oLEVEL(oLEVEL), .oOVERFLOW(oOVERFLOW), .oSYNC_ERR(oSYNC_ERR),
    .iCLR_ERR(iCLR_ERR)
  );

  always #5 iCLK = ~iCLK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queue of {sof,R,G,B} pixels, list of bytes of the pixel being built
  logic [24:0] m_q[$];
  logic [7:0]  m_part[$];
  bit          m_part_sof;
  bit          m_ovf, m_serr;
  bit          m_pv, m_psof;
  logic [7:0]  m_pd;

  task automatic model_reset();
    m_q.delete();
    m_part.delete();
    m_part_sof = 1'b0;
    m_ovf = 1'b0; m_serr = 1'b0;
    m_pv = 1'b0; m_psof = 1'b0; m_pd = 8'd0;
  endtask

  // Effect of one rising edge: sample whose data is on the bus now arrives
  task automatic model_edge(input bit rdy, input bit clr);
    bit set_o, set_s;
    logic [24:0] pix;
    set_o = 1'b0; set_s = 1'b0;
    if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
    if (m_pv) begin
      if (m_psof) begin
        if (m_part.size() != 0) set_s = 1'b1;
        m_part.delete();
        m_part_sof = 1'b1;
        m_part.push_back(m_pd);
      end else begin
        if (m_part.size() == 0) m_part_sof = 1'b0;
        m_part.push_back(m_pd);
        if (m_part.size() == 3) begin
          pix = {m_part_sof, m_part[0], m_part[1], m_part[2]};
          m_part.delete();
          if (m_q.size() < DEPTH) m_q.push_back(pix);
          else set_o = 1'b1;
        end
      end
    end
    m_ovf  = set_o | (m_ovf  & ~clr);
    m_serr = set_s | (m_serr & ~clr);
  endtask

  // One clock: called at a falling edge, returns at the next falling edge.
  // iDATA carries the byte of the sample whose valid was driven last cycle.
  task automatic cyc(input bit v, input bit sof, input logic [7:0] d,
                     input bit rdy, input bit clr);
    iDATA    = m_pv ? m_pd : 8'($urandom);
    iVALID   = v;
    iSOF     = sof;
    iREADY   = rdy;
    iCLR_ERR = clr;
    @(posedge iCLK);
    model_edge(rdy, clr);
    m_pv = v; m_psof = sof; m_pd = d;
    @(negedge iCLK);
  endtask

  task automatic send_pixel(input logic [23:0] p, input bit sof, input bit rdy);
    cyc(1'b1, sof,  p[23:16], rdy, 1'b0);
    cyc(1'b1, 1'b0, p[15:8],  rdy, 1'b0);
    cyc(1'b1, 1'b0, p[7:0],   rdy, 1'b0);
  endtask

  task automatic apply_reset();
    iVALID = 1'b0; iSOF = 1'b0; iREADY = 1'b0; iCLR_ERR = 1'b0; iDATA = 8'd0;
    iRST_N = 1'b0;
    model_reset();
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b1;
  endtask

  task automatic test_reset();
    iRST_N = 1'b1;
    @(negedge iCLK);
    apply_reset();
    n_cmp++; if (oVALID !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", oVALID); end
    n_cmp++; if (oLEVEL !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", oLEVEL); end
    n_cmp++; if (oPIXEL !== 24'd0 || oSOF !== 1'b0) begin n_err++; $display("FAIL reset_head: got %h/%b want 0/0", oPIXEL, oSOF); end
    n_cmp++; if (oOVERFLOW !== 1'b0 || oSYNC_ERR !== 1'b0) begin n_err++; $display("FAIL reset_flags: got %b%b want 00", oOVERFLOW, oSYNC_ERR); end
  endtask

  task automatic test_basic();
    send_pixel(24'h102030, 1'b1, 1'b1);
    n_cmp++; if (oVALID !== 1'b0) begin n_err++; $display("FAIL basic_early: got valid %b want 0", oVALID); end
    cyc(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    n_cmp++; if (oVALID !== 1'b1 || oLEVEL !== 3'd1) begin n_err++; $display("FAIL basic_vis: got v=%b lvl=%0d want 1/1", oVALID, oLEVEL); end
    n_cmp++; if (oPIXEL !== 24'h102030 || oSOF !== 1'b1) begin n_err++; $display("FAIL basic_pix: got %h sof=%b want 102030 sof=1", oPIXEL, oSOF); end
    cyc(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    n_cmp++; if (oLEVEL !== 3'd0 || oVALID !== 1'b0) begin n_err++; $display("FAIL basic_pop: got lvl=%0d v=%b want 0/0", oLEVEL, oVALID); end
  endtask

  task automatic test_overflow();
    logic [23:0] px[5];
    for (int i = 0; i < 5; i++) px[i] = 24'($urandom);
    for (int i = 0; i < 5; i++) send_pixel(px[i], 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    n_cmp++; if (oLEVEL !== 3'd4) begin n_err++; $display("FAIL ovf_level: got %0d want 4", oLEVEL); end
    n_cmp++; if (oOVERFLOW !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", oOVERFLOW); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (oPIXEL !== px[i] || oVALID !== 1'b1) begin n_err++; $display("FAIL ovf_order%0d: got %h v=%b want %h", i, oPIXEL, oVALID, px[i]); end
      cyc(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    end
    n_cmp++; if (oLEVEL !== 3'd0) begin n_err++; $display("FAIL ovf_drain: got %0d want 0", oLEVEL); end
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    n_cmp++; if (oOVERFLOW !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", oOVERFLOW); end
  endtask

  task automatic test_full_pop();
    logic [23:0] px[5];
    for (int i = 0; i < 5; i++) px[i] = 24'($urandom);
    for (int i = 0; i < 4; i++) send_pixel(px[i], 1'b0, 1'b0);
    send_pixel(px[4], 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    n_cmp++; if (oLEVEL !== 3'd4) begin n_err++; $display("FAIL fullpop_level: got %0d want 4", oLEVEL); end
    n_cmp++; if (oOVERFLOW !== 1'b0) begin n_err++; $display("FAIL fullpop_ovf: got %b want 0", oOVERFLOW); end
    n_cmp++; if (oPIXEL !== px[1]) begin n_err++; $display("FAIL fullpop_head: got %h want %h", oPIXEL, px[1]); end
    for (int i = 1; i < 5; i++) begin
      n_cmp++; if (oPIXEL !== px[i]) begin n_err++; $display("FAIL fullpop_order%0d: got %h want %h", i, oPIXEL, px[i]); end
      cyc(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    end
    n_cmp++; if (oVALID !== 1'b0) begin n_err++; $display("FAIL fullpop_empty: got %b want 0", oVALID); end
  endtask

  task automatic test_sync();
    cyc(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'hBB, 1'b0, 1'b0);
    send_pixel(24'h010203, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    n_cmp++; if (oSYNC_ERR !== 1'b1) begin n_err++; $display("FAIL sync_flag: got %b want 1", oSYNC_ERR); end
    n_cmp++; if (oLEVEL !== 3'd1 || oPIXEL !== 24'h010203 || oSOF !== 1'b1) begin n_err++; $display("FAIL sync_pix: got lvl=%0d %h sof=%b want 1 010203 1", oLEVEL, oPIXEL, oSOF); end
    cyc(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
    n_cmp++; if (oSYNC_ERR !== 1'b0 || oVALID !== 1'b0) begin n_err++; $display("FAIL sync_clear: got err=%b v=%b want 0/0", oSYNC_ERR, oVALID); end
  endtask

  task automatic test_gap();
    cyc(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'hC3, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h7E, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    n_cmp++; if (oPIXEL !== 24'h5AC37E || oLEVEL !== 3'd1 || oSOF !== 1'b0) begin n_err++; $display("FAIL gap_pix: got %h lvl=%0d sof=%b want 5ac37e 1 0", oPIXEL, oLEVEL, oSOF); end
    n_cmp++; if (oOVERFLOW !== 1'b0 || oSYNC_ERR !== 1'b0) begin n_err++; $display("FAIL gap_flags: got %b%b want 00", oOVERFLOW, oSYNC_ERR); end
    cyc(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    send_pixel(24'hA1B2C3, 1'b1, 1'b0);
    send_pixel(24'hD4E5F6, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    n_cmp++; if (oLEVEL !== 3'd2 || oSYNC_ERR !== 1'b1) begin n_err++; $display("FAIL rstmid_pre: got lvl=%0d err=%b want 2/1", oLEVEL, oSYNC_ERR); end
    iRST_N = 1'b0;
    #1;
    n_cmp++; if (oVALID !== 1'b0 || oLEVEL !== 3'd0 || oSYNC_ERR !== 1'b0 || oOVERFLOW !== 1'b0) begin n_err++; $display("FAIL rstmid_async: got v=%b lvl=%0d flags=%b%b want 0 0 00", oVALID, oLEVEL, oOVERFLOW, oSYNC_ERR); end
    @(negedge iCLK);
    apply_reset();
    send_pixel(24'h445566, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    n_cmp++; if (oLEVEL !== 3'd1 || oPIXEL !== 24'h445566) begin n_err++; $display("FAIL rstmid_after: got lvl=%0d %h want 1 445566", oLEVEL, oPIXEL); end
    cyc(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    n_cmp++; if (oVALID !== 1'b0 || oSYNC_ERR !== 1'b0) begin n_err++; $display("FAIL rstmid_single: got v=%b err=%b want 0/0", oVALID, oSYNC_ERR); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      cyc(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), 8'($urandom),
          ($urandom_range(0, 1) == 1), ($urandom_range(0, 19) == 0));
      n_cmp++;
      if (oLEVEL !== LEVEL_W'(m_q.size()) || oVALID !== (m_q.size() != 0)) begin
        n_err++; $display("FAIL rnd_level c%0d: got lvl=%0d v=%b want %0d", c, oLEVEL, oVALID, m_q.size());
      end
      n_cmp++;
      if (oOVERFLOW !== m_ovf || oSYNC_ERR !== m_serr) begin
        n_err++; $display("FAIL rnd_flags c%0d: got ovf=%b serr=%b want %b %b", c, oOVERFLOW, oSYNC_ERR, m_ovf, m_serr);
      end
      if (m_q.size() > 0) begin
        n_cmp++;
        if ({oSOF, oPIXEL} !== m_q[0]) begin
          n_err++; $display("FAIL rnd_head c%0d: got %h want %h", c, {oSOF, oPIXEL}, m_q[0]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    iRST_N = 1'b1; iVALID = 1'b0; iSOF = 1'b0; iREADY = 1'b0; iCLR_ERR = 1'b0; iDATA = 8'd0;
    test_reset();
    test_basic();
    test_overflow();
    test_full_pop();
    test_sync();
    test_gap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gamma_pixel_packer.md
Name: gamma_pixel_packer

Overview:
Downstream consumer of the three per-channel gamma LUT stages. Takes the time-multiplexed 8-bit corrected sample stream (R, G, B order) and assembles 24-bit RGB pixels. Buffers the pixels in a small first-word-fall-through FIFO with valid/ready backpressure toward the frame writer, and flags sync and overflow errors.

Parameters:
DEPTH, 4, FIFO depth in pixels; power of two, 2..16
LEVEL_W, 3, width of oLEVEL; equals log2(DEPTH)+1

Ports:
iCLK  in  1  system clock, rising edge
iRST_N  in  1  asynchronous active-low reset
iVALID  in  1  LUT valid_out; combinational copy of LUT valid_in, one cycle ahead of iDATA
iSOF  in  1  start of frame; aligned with iVALID on the first R sample of a frame
iDATA  in  8  LUT registered result
oPIXEL  out  24  FIFO head {R[23:16], G[15:8], B[7:0]}
oVALID  out  1  FIFO not empty
iREADY  in  1  downstream accepts oPIXEL when oVALID&&iREADY
oSOF  out  1  head pixel is the first pixel of a frame
oLEVEL  out  LEVEL_W  FIFO occupancy, 0..DEPTH
oOVERFLOW  out  1  sticky: a completed pixel was dropped because the FIFO was full
oSYNC_ERR  out  1  sticky: iSOF arrived while a partial pixel was held
iCLR_ERR  in  1  synchronous clear of both sticky flags

Behaviour:
- Reset (async assert, sync release): all outputs 0; FIFO empty; channel counter = 0; partial R/G registers = 0; internal valid/SOF delays = 0. Reset mid-pixel discards the partial pixel and all FIFO contents.
- Alignment: iVALID and iSOF are registered once (v_d, sof_d). iDATA is qualified only by v_d, because the LUT result lags its valid by one clock. iVALID is never used to sample iDATA directly.
- Channel counter ch in {0,1,2}. Each edge with v_d=1:
  - ch=0: capture R; ch->1.
  - ch=1: capture G; ch->2.
  - ch=2: form {R,G,iDATA}; push it with the frame flag; ch->0.
- The frame flag of a pixel is sof_d as captured with its R sample.
- SOF resync: when v_d=1 and sof_d=1, the sample is treated as R and ch->1, whatever the current ch value. If ch!=0 at that moment, the held partial pixel is discarded and oSYNC_ERR is set.
- FIFO: first-word fall-through. oPIXEL/oSOF show the head combinationally from registered storage. Pop occurs on oVALID&&iREADY.
- Push is accepted when level<DEPTH, or when level==DEPTH and a pop occurs in the same cycle.
- If a push is not accepted, the pixel is dropped, oOVERFLOW is set, and FIFO state is unchanged. There is no backpressure to the LUT stage.
- Simultaneous push and pop: level is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. oLEVEL updates on the same edge as the push/pop.
- Latency: iVALID high at edge k (B sample) → iDATA sampled at edge k+1 → oVALID=1 after edge k+1 when the FIFO was empty. That gives one cycle from the B data at the packer input to pixel visibility.
- iCLR_ERR clears the sticky flags at the next edge. If a set condition occurs in the same cycle, set wins.
- iREADY with oVALID=0 has no effect.
- iDATA is ignored when v_d=0. Gaps between samples of any length are permitted mid-pixel.

Test Plan:
1. After reset, drive iVALID with iSOF on the first sample, samples 0x10, 0x20, 0x30 (data one cycle later), iREADY=1 → oPIXEL=0x102030 and oSOF=1 visible one cycle after the 0x30 data; oLEVEL goes 0→1→0.
2. iREADY=0, push 5 pixels with DEPTH=4 → oLEVEL=4, oOVERFLOW=1; popping 4 yields the first four pixels in order. Then iCLR_ERR → oOVERFLOW=0.
3. With FIFO full and iREADY=1 in the same cycle a 5th pixel completes → no overflow, oLEVEL stays 4, head advances.
4. Send R=0xAA, G=0xBB, then iSOF with R=0x01, G=0x02, B=0x03 → oSYNC_ERR=1; the only pixel emitted is 0x010203 with oSOF=1.
5. Insert 3 idle cycles between G and B of a pixel → pixel assembled correctly; no error flags.
6. Assert iRST_N low with 2 pixels queued and ch=1 → oVALID=0, oLEVEL=0, flags 0. The next full triple after release produces exactly one correct pixel.
